// File: rtl/audio_sample_pacer.sv
// Paces buffered audio bytes out at one sample per CLK_DIV clocks.
// Bytes are primed into a circular FIFO until half full, then played until it runs dry.
module audio_sample_pacer #(
  parameter int          CLK_DIV    = 12500,
  parameter int          DEPTH_LOG2 = 6,
  parameter logic [7:0]  MIDSCALE   = 8'h80
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  input  logic                  clear_flags,
  output logic [7:0]            sample_out,
  output logic                  sample_strobe,
  output logic                  playing,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic                  overflow,
  output logic                  underrun
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]      TICK_VAL = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   FILL_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   HALF_LVL = {2'b01, {(DEPTH_LOG2-1){1'b0}}};

  // The state bit is observable directly on the playing output.
  typedef enum logic {
    PRIME = 1'b0,
    PLAY  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   fill_q, fill_d;
  logic [7:0]            sample_q, sample_d;
  logic                  strobe_q, strobe_d;
  logic                  ovf_q, ovf_d;
  logic                  unr_q, unr_d;
  logic [7:0]            mem_q [DEPTH];

  logic tick, full, empty, pop, starve, push, ovf_evt;

  always_comb begin
    tick    = (cnt_q == TICK_VAL);
    full    = (fill_q == FULL_LVL);
    empty   = (fill_q == '0);
    pop     = (state_q == PLAY) && tick && !empty;
    starve  = (state_q == PLAY) && tick && empty;
    // A push into a full FIFO still fits when the same edge pops the head.
    push    = in_valid && (!full || pop);
    ovf_evt = in_valid && full && !pop;

    cnt_d    = tick ? '0 : cnt_q + CNT_ONE;
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    fill_d = fill_q;
    case ({push, pop})
      2'b10:   fill_d = fill_q + FILL_ONE;
      2'b01:   fill_d = fill_q - FILL_ONE;
      default: fill_d = fill_q;
    endcase

    state_d = state_q;
    case (state_q)
      PRIME:   if (fill_q >= HALF_LVL) state_d = PLAY;
      PLAY:    if (starve) state_d = PRIME;
      default: state_d = PRIME;
    endcase

    sample_d = sample_q;
    strobe_d = 1'b0;
    if (pop) begin
      sample_d = mem_q[rd_ptr_q];
      strobe_d = 1'b1;
    end else if (starve) begin
      sample_d = MIDSCALE;
      strobe_d = 1'b1;
    end

    // A flag event in the same cycle as clear_flags wins over the clear.
    ovf_d = ovf_evt | (ovf_q & ~clear_flags);
    unr_d = starve  | (unr_q & ~clear_flags);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= PRIME;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      sample_q <= MIDSCALE;
      strobe_q <= 1'b0;
      ovf_q    <= 1'b0;
      unr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      sample_q <= sample_d;
      strobe_q <= strobe_d;
      ovf_q    <= ovf_d;
      unr_q    <= unr_d;
    end
  end

  // Storage is never reset; pointers alone decide what is readable.
  always_ff @(posedge clk) begin
    if (resetn && push) mem_q[wr_ptr_q] <= in_data;
  end

  assign sample_out    = sample_q;
  assign sample_strobe = strobe_q;
  assign playing       = (state_q == PLAY);
  assign fill_level    = fill_q;
  assign overflow      = ovf_q;
  assign underrun      = unr_q;

endmodule

// File: tb/tb_audio_sample_pacer.sv
// Bench for audio_sample_pacer with small parameters and a queue-based reference model.
module tb_audio_sample_pacer;
  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 8;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       clear_flags = 1'b0;
  logic [7:0] sample_out;
  logic       sample_strobe, playing, overflow, underrun;
  logic [3:0] fill_level;

  audio_sample_pacer #(.CLK_DIV(CLK_DIV), .DEPTH_LOG2(3), .MIDSCALE(8'h80)) dut (
    .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
    .clear_flags(clear_flags), .sample_out(sample_out), .sample_strobe(sample_strobe),
    .playing(playing), .fill_level(fill_level), .overflow(overflow), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: buffered bytes in arrival order plus the observable registers.
  logic [7:0] exp_q[$];
  int         m_phase;
  logic       m_play, m_strobe, m_ovf, m_unr;
  logic [7:0] m_sample;
  logic [15:0] got_v, exp_v;

  task automatic step(input logic v, input logic [7:0] d, input logic clr, input logic rst);
    bit tk, pop, starve, drop;
    int sz;
    in_valid = v; in_data = d; clear_flags = clr; resetn = rst;
    if (!rst) begin
      exp_q.delete();
      m_phase = 0; m_play = 0; m_sample = 8'h80; m_strobe = 0; m_ovf = 0; m_unr = 0;
    end else begin
      tk     = (m_phase == CLK_DIV - 1);
      sz     = exp_q.size();
      pop    = m_play && tk && sz > 0;
      starve = m_play && tk && sz == 0;
      drop   = v && sz == DEPTH && !pop;
      m_phase  = (m_phase + 1) % CLK_DIV;
      m_strobe = m_play && tk;
      if (pop) m_sample = exp_q.pop_front();
      else if (starve) m_sample = 8'h80;
      if (v && !drop) exp_q.push_back(d);
      if (!m_play) m_play = (sz >= DEPTH / 2);
      else if (starve) m_play = 0;
      m_ovf = drop || (m_ovf && !clr);
      m_unr = starve || (m_unr && !clr);
    end
    @(posedge clk); #1;
    got_v = {sample_out, sample_strobe, playing, fill_level, overflow, underrun};
    exp_v = {m_sample, m_strobe, m_play, 4'(exp_q.size()), m_ovf, m_unr};
  endtask

  task automatic test_reset();
    step(0, 8'h00, 0, 0);
    step(1, 8'h55, 1, 0);
    n_vec++;
    if (sample_out !== 8'h80 || fill_level !== 4'd0 || playing !== 1'b0 ||
        overflow !== 1'b0 || underrun !== 1'b0 || sample_strobe !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got out=%h fill=%0d play=%b ovf=%b unr=%b stb=%b exp 80/0/0/0/0/0",
               sample_out, fill_level, playing, overflow, underrun, sample_strobe);
    end
  endtask

  task automatic test_prime_play();
    logic [7:0] pb [4];
    logic [7:0] seen [4];
    int at [4];
    int k = 0;
    pb = '{8'h10, 8'h20, 8'h30, 8'h40};
    for (int i = 0; i < 4; i++) begin
      step(1, pb[i], 0, 1);
      n_vec++;
      if (got_v !== exp_v) begin n_err++; $display("FAIL prime_model got %h exp %h", got_v, exp_v); end
      if (i < 3) begin
        n_vec++;
        if (playing !== 1'b0 || sample_out !== 8'h80) begin
          n_err++; $display("FAIL prime_hold got play=%b out=%h exp 0/80", playing, sample_out);
        end
      end
    end
    for (int c = 0; c < 30 && k < 4; c++) begin
      step(0, 8'h00, 0, 1);
      n_vec++;
      if (got_v !== exp_v) begin n_err++; $display("FAIL play_model cyc %0d got %h exp %h", c, got_v, exp_v); end
      if (c == 0) begin
        n_vec++;
        if (playing !== 1'b1) begin n_err++; $display("FAIL play_enter got %b exp 1", playing); end
      end
      if (sample_strobe === 1'b1) begin seen[k] = sample_out; at[k] = c; k++; end
    end
    n_vec++;
    if (k != 4) begin n_err++; $display("FAIL play_strobes got %0d exp 4", k); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (seen[i] !== pb[i]) begin n_err++; $display("FAIL play_order[%0d] got %h exp %h", i, seen[i], pb[i]); end
        if (i > 0) begin
          n_vec++;
          if (at[i] - at[i-1] != 4) begin
            n_err++; $display("FAIL play_gap[%0d] got %0d exp 4", i, at[i] - at[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_underrun();
    bit hit = 0;
    for (int c = 0; c < 10 && !hit; c++) begin
      step(0, 8'h00, 0, 1);
      n_vec++;
      if (got_v !== exp_v) begin n_err++; $display("FAIL underrun_model cyc %0d got %h exp %h", c, got_v, exp_v); end
      if (sample_strobe === 1'b1) begin
        hit = 1;
        n_vec++;
        if (sample_out !== 8'h80 || underrun !== 1'b1 || playing !== 1'b0) begin
          n_err++; $display("FAIL underrun_tick got out=%h unr=%b play=%b exp 80/1/0", sample_out, underrun, playing);
        end
      end
    end
    n_vec++;
    if (!hit) begin n_err++; $display("FAIL underrun_budget got no strobe exp strobe within 10"); end
  endtask

  task automatic test_clear_flags();
    int c = 0;
    while (c < 40 && !(exp_q.size() == DEPTH && m_phase != CLK_DIV - 1)) begin
      step(1, 8'(8'hC0 + c), 0, 1);
      n_vec++;
      if (got_v !== exp_v) begin n_err++; $display("FAIL clear_fill_model cyc %0d got %h exp %h", c, got_v, exp_v); end
      c++;
    end
    step(1, 8'hEE, 1, 1);
    n_vec++;
    if (overflow !== 1'b1 || underrun !== 1'b0) begin
      n_err++; $display("FAIL clear_with_event got ovf=%b unr=%b exp 1/0", overflow, underrun);
    end
    step(0, 8'h00, 1, 1);
    n_vec++;
    if (overflow !== 1'b0 || underrun !== 1'b0) begin
      n_err++; $display("FAIL clear_alone got ovf=%b unr=%b exp 0/0", overflow, underrun);
    end
    for (int i = 0; i < 50; i++) begin
      step(0, 8'h00, 0, 1);
      n_vec++;
      if (got_v !== exp_v) begin n_err++; $display("FAIL clear_drain_model cyc %0d got %h exp %h", i, got_v, exp_v); end
    end
  endtask

  task automatic test_overflow();
    step(0, 8'h00, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step(1, 8'(8'h50 + i), 0, 1);
      n_vec++;
      if (got_v !== exp_v) begin n_err++; $display("FAIL ovf_model cyc %0d got %h exp %h", i, got_v, exp_v); end
    end
    n_vec++;
    if (overflow !== 1'b1 || fill_level !== 4'd8) begin
      n_err++; $display("FAIL ovf_flag got ovf=%b fill=%0d exp 1/8", overflow, fill_level);
    end
    for (int i = 0; i < 60; i++) begin
      step(0, 8'h00, 0, 1);
      n_vec++;
      if (got_v !== exp_v) begin n_err++; $display("FAIL ovf_drain_model cyc %0d got %h exp %h", i, got_v, exp_v); end
    end
  endtask

  task automatic test_reset_mid();
    int c = 0;
    step(0, 8'h00, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 8'(8'h60 + i), 0, 1);
    while (c < 20 && !(m_play && exp_q.size() == 5)) begin step(0, 8'h00, 0, 1); c++; end
    n_vec++;
    if (playing !== 1'b1 || fill_level !== 4'd5) begin
      n_err++; $display("FAIL midreset_setup got play=%b fill=%0d exp 1/5", playing, fill_level);
    end
    step(1, 8'h77, 1, 0);
    n_vec++;
    if (sample_out !== 8'h80 || fill_level !== 4'd0 || playing !== 1'b0 || sample_strobe !== 1'b0) begin
      n_err++; $display("FAIL midreset_state got out=%h fill=%0d play=%b stb=%b exp 80/0/0/0",
                        sample_out, fill_level, playing, sample_strobe);
    end
    for (int i = 0; i < 40; i++) begin
      step(i < 4, 8'(8'hA0 + i), 0, 1);
      n_vec++;
      if (got_v !== exp_v) begin n_err++; $display("FAIL midreset_model cyc %0d got %h exp %h", i, got_v, exp_v); end
      if (sample_strobe === 1'b1) begin
        n_vec++;
        if (sample_out !== 8'h80 && (sample_out < 8'hA0 || sample_out > 8'hA3)) begin
          n_err++; $display("FAIL midreset_stale got %h exp 80 or A0..A3", sample_out);
        end
      end
    end
  endtask

  task automatic test_random();
    step(0, 8'h00, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 30, 8'($urandom), $urandom_range(0, 19) == 0,
           $urandom_range(0, 499) != 0);
      n_vec++;
      if (got_v !== exp_v) begin n_err++; $display("FAIL random_model cyc %0d got %h exp %h", i, got_v, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_prime_play();
    test_underrun();
    test_clear_flags();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
